sys_bus_arbiter: RTL

//  Parametrised shared-memory arbiter plus memory-mapped I/O register bank for the 16-bit

---
 rtl/sys_bus_arbiter_pkg.sv | 23 ++
 rtl/sys_bus_arbiter_if.sv | 39 +++
 rtl/sys_bus_arbiter_rr.sv | 52 +++++
 rtl/sys_bus_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sys_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_pkg
// Description : Shared constants and types for the system bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_bus_pkg;

    localparam logic [15:0] IO_BASE_DFLT = 16'hFFF0;

    // MMIO register map, offsets from IO_BASE
    localparam int IO_SCORE = 0;
    localparam int IO_P1    = 1;
    localparam int IO_P2    = 2;
    localparam int IO_P3    = 3;

    typedef enum logic [0:0] {
        RD_SRC_RAM = 1'b0,
        RD_SRC_IO  = 1'b1
    } rd_src_t;

endpackage : sys_bus_pkg
`default_nettype wire

// File: rtl/sys_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_arbiter_if
// Description : Master-side request bus, RAM port and MMIO export bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_bus_arbiter_if #(
    parameter int NUM_M  = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NUM_IO = 4
);
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M-1:0]        m_we;
    logic [NUM_M-1:0]        m_lock;
    logic [NUM_M*ADDR_W-1:0] m_adr;
    logic [NUM_M*DATA_W-1:0] m_wdata;
    logic [NUM_M-1:0]        m_gnt;
    logic [NUM_M-1:0]        m_rvalid;
    logic [DATA_W-1:0]       m_rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_adr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic [NUM_IO*DATA_W-1:0] io_regs;

    modport slave (
        input  m_req, m_we, m_lock, m_adr, m_wdata, mem_rdata,
        output m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_adr, mem_wdata, io_regs
    );

    modport master (
        output m_req, m_we, m_lock, m_adr, m_wdata, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata, mem_en, mem_we, mem_adr, mem_wdata, io_regs
    );

endinterface : sys_bus_arbiter_if
`default_nettype wire

// File: rtl/sys_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant with lock override.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  wire logic [NUM_M-1:0] i_req,
    input  wire logic             i_lock_vld,
    input  wire logic [IDX_W-1:0] i_lock_idx,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [NUM_M-1:0] o_gnt,
    output logic      [IDX_W-1:0] o_gnt_idx,
    output logic                  o_gnt_vld
);

    int               w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_sum     = 0;
        w_cand    = '0;
        if (i_lock_vld && i_req[i_lock_idx]) begin
            o_gnt_idx = i_lock_idx;
            o_gnt_vld = 1'b1;
        end else begin
            // Scan ptr, ptr+1, ... wrapping at NUM_M; first requester wins
            for (int k = 0; k < NUM_M; k++) begin
                w_sum = int'(i_ptr) + k;
                if (w_sum >= NUM_M) begin
                    w_sum = w_sum - NUM_M;
                end
                w_cand = IDX_W'(w_sum);
                if (!o_gnt_vld && i_req[w_cand]) begin
                    o_gnt_idx = w_cand;
                    o_gnt_vld = 1'b1;
                end
            end
        end
        if (o_gnt_vld) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_arbiter
// Description : Round-robin shared-RAM arbiter with MMIO register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int                NUM_M   = 2,
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 16,
    parameter int                NUM_IO  = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DFLT)
) (
    input wire logic clk,
    input wire logic rst,
    sys_bus_arbiter_if.slave bus
);

    localparam int IDX_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int IO_IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    logic [NUM_M-1:0]    w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_vld;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [ADDR_W-1:0]   w_adr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_we;
    logic [ADDR_W-1:0]   w_off;
    logic                w_io_hit;
    logic [IO_IDX_W-1:0] w_io_idx;
    logic                w_rd;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic                r_lock_vld;
    logic [IDX_W-1:0]    r_lock_idx;
    logic [NUM_M-1:0]    r_rvalid;
    logic                r_rd_pending;
    rd_src_t             r_rd_src;
    logic [DATA_W-1:0]   r_io_rdata;
    logic [DATA_W-1:0]   r_io [NUM_IO];

    rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req      (bus.m_req),
        .i_lock_vld (r_lock_vld),
        .i_lock_idx (r_lock_idx),
        .i_ptr      (r_rr_ptr),
        .o_gnt      (w_gnt),
        .o_gnt_idx  (w_gnt_idx),
        .o_gnt_vld  (w_gnt_vld)
    );

    // One-hot AND-OR mux of the granted master's request fields
    always_comb begin
        w_adr   = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_gnt[i]) begin
                w_adr   = bus.m_adr[i*ADDR_W +: ADDR_W];
                w_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
                w_we    = bus.m_we[i];
            end
        end
    end

    assign w_off     = w_adr - IO_BASE;
    assign w_io_hit  = w_gnt_vld && (w_adr >= IO_BASE) && (w_off < ADDR_W'(NUM_IO));
    assign w_io_idx  = w_off[IO_IDX_W-1:0];
    assign w_rd      = w_gnt_vld && !w_we;
    assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_M - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign bus.m_gnt     = w_gnt;
    assign bus.mem_en    = w_gnt_vld && !w_io_hit;
    assign bus.mem_we    = w_gnt_vld && !w_io_hit && w_we;
    assign bus.mem_adr   = w_adr;
    assign bus.mem_wdata = w_wdata;
    assign bus.m_rvalid  = r_rvalid;

    // RAM data arrives one cycle after the strobe, so it bypasses the register
    assign bus.m_rdata = (r_rd_pending && (r_rd_src == RD_SRC_RAM)) ? bus.mem_rdata : r_io_rdata;

    for (genvar k = 0; k < NUM_IO; k++) begin : g_io_pack
        assign bus.io_regs[k*DATA_W +: DATA_W] = r_io[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_lock_vld   <= 1'b0;
            r_lock_idx   <= '0;
            r_rvalid     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_src     <= RD_SRC_RAM;
            r_io_rdata   <= '0;
            for (int k = 0; k < NUM_IO; k++) begin
                r_io[k] <= '0;
            end
        end else begin
            if (w_gnt_vld) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_lock_vld <= |(w_gnt & bus.m_lock);
                r_lock_idx <= w_gnt_idx;
            end else begin
                r_lock_vld <= 1'b0;
            end

            r_rvalid     <= w_rd ? w_gnt : '0;
            r_rd_pending <= w_rd;
            if (w_rd) begin
                r_rd_src <= w_io_hit ? RD_SRC_IO : RD_SRC_RAM;
            end

            if (w_io_hit && !w_we) begin
                r_io_rdata <= r_io[w_io_idx];
            end
            if (w_io_hit && w_we) begin
                r_io[w_io_idx] <= w_wdata;
            end
        end
    end

endmodule : sys_bus_arbiter
`default_nettype wire
